key_input_ctrl: RTL
===================

Name: key_input_ctrl

Overview:
Parametrised front end for board push-buttons and switches. It synchronises W raw inputs, debounces them with a cycle-count filter and normalises polarity, then produces per-channel level, press, release and auto-repeat pulses. It sits between the board pins and the CPU or FSM logic in the board top, so downstream logic receives clean single-cycle events. Each channel has an optional auto-repeat mode that earlier debouncers lacked.

Parameters:
W, 4, number of input channels
ACTIVE_LOW, 1, 1 = raw input low means pressed; 0 = raw high means pressed
SYNC_STAGES, 2, synchroniser flop count (>= 2)
DB_CYCLES, 100000, consecutive stable cycles required to accept a change (2 ms at 50 MHz); >= 2
REPEAT_DELAY, 25000000, cycles from press to first repeat pulse; >= 2
REPEAT_PERIOD, 5000000, cycles between later repeat pulses; >= 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
raw_in  in  W  unsynchronised board inputs
repeat_en  in  W  per-channel auto-repeat enable; synchronous to clk
pressed  out  W  debounced level, 1 = pressed
press  out  W  one-cycle pulse when pressed rises
release  out  W  one-cycle pulse when pressed falls
repeat  out  W  one-cycle auto-repeat pulse
any_press  out  1  OR of press

Behaviour:
- Reset is asynchronous and active-low; all state clears while reset_n = 0.
  - Sync flops load the idle level: 1 if ACTIVE_LOW, else 0.
  - All outputs are 0, all counters are 0, and every FSM is in RELEASED.
- Polarity: lvl = sync_out XOR ACTIVE_LOW, so lvl = 1 means pressed.
- Sync chain: SYNC_STAGES flops per channel. No combinational path exists from raw_in to any output.
- Debounce, per channel, with a db_cnt of width clog2(DB_CYCLES):
  - If lvl == pressed, db_cnt <= 0.
  - Else if db_cnt == DB_CYCLES-1, then pressed <= lvl and db_cnt <= 0.
  - Else db_cnt increments.
  - A glitch shorter than DB_CYCLES never changes pressed.
  - Latency from a clean raw_in edge to pressed changing: SYNC_STAGES + DB_CYCLES cycles.
- Pulse timing:
  - press is registered in the same cycle that pressed goes 0->1, so press and pressed are first high together.
  - release is high in the cycle pressed goes 1->0.
- Repeat FSM, per channel, with rp_cnt of width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)):
  - RELEASED: on press, go to HOLD_DELAY with rp_cnt = 0.
  - HOLD_DELAY: rp_cnt increments. When rp_cnt == REPEAT_DELAY-1 and repeat_en = 1: repeat = 1, rp_cnt = 0, go to HOLD_REPEAT.
  - HOLD_REPEAT: rp_cnt increments. When rp_cnt == REPEAT_PERIOD-1: repeat = 1, rp_cnt = 0.
  - Any state: pressed falling returns the FSM to RELEASED in the release cycle. No repeat pulse is ever issued in the release cycle.
  - repeat_en = 0 while in HOLD_*: go to HOLD_DELAY with rp_cnt = 0, and no pulses. Re-enabling restarts the full REPEAT_DELAY.
  - First repeat lands REPEAT_DELAY cycles after the press pulse; later repeats are spaced REPEAT_PERIOD cycles.
  - repeat and press are never high in the same cycle.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- reset_n asserted mid-hold: no release pulse is emitted, and after reset the channel starts from the idle state.
- Counter wrap-around is impossible by construction; widths are derived from the parameters.

Decomposition:
- Package key_input_pkg holds:
  - typedef enum logic [1:0] rep_state_t {RELEASED, HOLD_DELAY, HOLD_REPEAT}
  - a clog2-based width helper function
- Sub-module key_channel implements one channel: sync, debounce and repeat FSM.
  - Outputs: pressed, press, release, repeat.
  - The top instantiates it with a generate loop over W and ORs press to form any_press.

Test Plan:
All tests use W=4, ACTIVE_LOW=1, SYNC_STAGES=2, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset and idle: reset_n=0 with raw_in=4'b0000, then release reset -> all outputs 0 during reset; after reset, pressed goes to 4'b1111 no earlier than 6 cycles later, with press pulses.
2. Clean press on ch0: raw_in[0] 1->0 -> pressed[0] and press[0] rise exactly 6 cycles later. press[0] is one cycle wide, any_press=1 in that same cycle, and channels 1-3 stay unchanged.
3. Glitch rejection: raw_in[1] low for 3 cycles, then high -> pressed[1], press[1] and release[1] stay 0 throughout.
4. Auto-repeat on ch2 with repeat_en[2]=1, held for 30 cycles after press -> repeat pulses at +10, +13, +16, ... cycles from press. On release, release[2] is a single pulse and no repeat occurs at or after it.
5. Repeat gating: hold ch3, drop repeat_en[3] at +5 and raise it again at +8 -> first repeat arrives at +18, not +10.
6. Simultaneous events plus reset mid-hold: press ch0 and ch1 together, then assert reset_n at +12 -> press=4'b0011 in one cycle; after reset, no release pulses and all outputs 0.

Source files
------------

// File: rtl/key_input_pkg.sv
// Shared types and width helpers for the key input front end.
package key_input_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } rep_state_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: synchroniser, cycle-count debounce, polarity fix-up,
// press/release edge pulses and a per-channel auto-repeat FSM.
module key_channel
  import key_input_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DB_CYCLES     = 100000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  input  logic i_repeat_en,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam logic            IDLE    = ACTIVE_LOW;
  localparam int unsigned     DBW     = cnt_width(DB_CYCLES);
  localparam int unsigned     RPW     = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [RPW-1:0]  RD_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0]  RP_LAST = RPW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DBW-1:0]         r_db_cnt;
  logic                   r_pressed;
  logic                   r_press;
  logic                   r_release;
  logic                   r_repeat;
  rep_state_t             r_state;
  logic [RPW-1:0]         r_rp_cnt;

  logic                   w_lvl;
  logic                   w_db_done;
  logic                   w_rise;
  logic                   w_fall;
  rep_state_t             w_state_nxt;
  logic [RPW-1:0]         w_rp_cnt_nxt;
  logic                   w_repeat_nxt;

  // Synchroniser chain, parked at the idle pin level in reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_sync <= {SYNC_STAGES{IDLE}};
    else            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_lvl     = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign w_db_done = (w_lvl != r_pressed) && (r_db_cnt == DB_LAST);
  assign w_rise    = w_db_done &  w_lvl;
  assign w_fall    = w_db_done & ~w_lvl;

  // Debounce filter; press/release are registered on the same edge as the level.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_db_cnt  <= '0;
      r_pressed <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      if (w_lvl == r_pressed) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_pressed <= w_lvl;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
    end
  end

  // Repeat FSM state, counter and pulse register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= RELEASED;
      r_rp_cnt <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rp_cnt <= w_rp_cnt_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  // Repeat FSM next state; a falling level overrides everything so no
  // repeat can coincide with the release pulse.
  always_comb begin
    w_state_nxt  = r_state;
    w_rp_cnt_nxt = r_rp_cnt + RPW'(1);
    w_repeat_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        w_rp_cnt_nxt = '0;
        if (w_rise) w_state_nxt = HOLD_DELAY;
      end
      HOLD_DELAY: begin
        if (!i_repeat_en) begin
          w_rp_cnt_nxt = '0;
        end else if (r_rp_cnt == RD_LAST) begin
          w_repeat_nxt = 1'b1;
          w_rp_cnt_nxt = '0;
          w_state_nxt  = HOLD_REPEAT;
        end
      end
      HOLD_REPEAT: begin
        if (!i_repeat_en) begin
          w_rp_cnt_nxt = '0;
          w_state_nxt  = HOLD_DELAY;
        end else if (r_rp_cnt == RP_LAST) begin
          w_repeat_nxt = 1'b1;
          w_rp_cnt_nxt = '0;
        end
      end
      default: begin
        w_rp_cnt_nxt = '0;
        w_state_nxt  = RELEASED;
      end
    endcase
    if (w_fall) begin
      w_state_nxt  = RELEASED;
      w_rp_cnt_nxt = '0;
      w_repeat_nxt = 1'b0;
    end
  end

  assign o_pressed = r_pressed;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_input_ctrl.sv
// Push-button / switch front end: W independent debounced channels with
// press, release and auto-repeat pulses, plus a combined press flag.
module key_input_ctrl
  import key_input_pkg::*;
#(
  parameter int unsigned W             = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DB_CYCLES     = 100000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_raw_in,
  input  logic [W-1:0] i_repeat_en,
  output logic [W-1:0] o_pressed,
  output logic [W-1:0] o_press,
  output logic [W-1:0] o_release,
  output logic [W-1:0] o_repeat,
  output logic         o_any_press
);

  for (genvar g = 0; g < W; g++) begin : gen_ch
    key_channel #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .SYNC_STAGES   (SYNC_STAGES),
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_raw       (i_raw_in[g]),
      .i_repeat_en (i_repeat_en[g]),
      .o_pressed   (o_pressed[g]),
      .o_press     (o_press[g]),
      .o_release   (o_release[g]),
      .o_repeat    (o_repeat[g])
    );
  end

  // Combined press flag from the registered per-channel pulses.
  always_comb o_any_press = |o_press;

endmodule
